div_issuer: RTL and testbench

- EX-stage initiator for the multi-cycle iterative divider.
- Detects DIV/DIVU in EX, latches operands and drives the divider's start/abandon handshake.
- Stalls the pipeline until the 64-bit result returns, then issues a one-cycle HI/LO write.
- Handles exception flush (abandon), downstream stall and a watchdog timeout.

---
 rtl/div_issuer_pkg.sv | 16 +
 rtl/div_issuer_if.sv | 33 +++
 rtl/div_issuer.sv | 104 ++++++++++
 tb/tb_div_issuer.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_issuer_pkg.sv
// div_issuer_pkg: shared data widths, zero constants and FSM encoding for the divide issuer.
package div_issuer_pkg;

    localparam int DATA_BUS_W = 32;
    localparam int DWORD_W    = 64;

    localparam logic [DATA_BUS_W-1:0] ZERO_WORD  = '0;
    localparam logic [DWORD_W-1:0]    ZERO_DWORD = '0;

    typedef enum logic [1:0] {
        DIV_ISS_IDLE = 2'd0,
        DIV_ISS_BUSY = 2'd1,
        DIV_ISS_DONE = 2'd2
    } div_iss_state_e;

endpackage

// File: rtl/div_issuer_if.sv
// div_issuer_if: start/abandon handshake and operand/result bus between the issuer and the iterative divider.
interface div_issuer_if;
    import div_issuer_pkg::*;

    logic                  div_start;
    logic                  div_abandon;
    logic                  div_signed;
    logic [DATA_BUS_W-1:0] div_opr1;
    logic [DATA_BUS_W-1:0] div_opr2;
    logic                  div_ready;
    logic [DWORD_W-1:0]    div_res;

    modport master (
        output div_start,
        output div_abandon,
        output div_signed,
        output div_opr1,
        output div_opr2,
        input  div_ready,
        input  div_res
    );

    modport slave (
        input  div_start,
        input  div_abandon,
        input  div_signed,
        input  div_opr1,
        input  div_opr2,
        output div_ready,
        output div_res
    );

endinterface

// File: rtl/div_issuer.sv
// div_issuer: EX-stage initiator that launches DIV/DIVU on the iterative divider, stalls the
// pipeline until the result returns, then pulses a single HI/LO write. Handles flush and a watchdog.
module div_issuer
    import div_issuer_pkg::*;
#(
    parameter int MAX_CYCLES = 40,
    parameter int CNT_W      = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_div_req,
    input  logic                  ex_signed,
    input  logic [DATA_BUS_W-1:0] ex_opr1,
    input  logic [DATA_BUS_W-1:0] ex_opr2,
    input  logic                  flush,
    input  logic                  stall_ext,
    div_issuer_if.master          div,
    output logic                  stall_req,
    output logic                  hilo_we,
    output logic [DATA_BUS_W-1:0] hi_out,
    output logic [DATA_BUS_W-1:0] lo_out,
    output logic                  div_timeout
);

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_CYCLES - 1);

    div_iss_state_e   state;
    logic [CNT_W-1:0] cnt;
    logic             wd_expire;

    // Watchdog fires on the last allowed BUSY cycle only if the divider has still not answered.
    always_comb begin
        wd_expire = (state == DIV_ISS_BUSY) && !div.div_ready && (cnt == CNT_LIMIT);
    end

    // Handshake and pipeline controls that must react within the cycle; forced low while in reset.
    always_comb begin
        div.div_abandon = 1'b0;
        div_timeout     = 1'b0;
        stall_req       = 1'b0;
        hilo_we         = 1'b0;
        if (!rst) begin
            div.div_abandon = (flush && (state != DIV_ISS_IDLE)) || wd_expire;
            div_timeout     = wd_expire && !flush;
            stall_req       = (state == DIV_ISS_BUSY) ||
                              ((state == DIV_ISS_IDLE) && ex_div_req && !flush);
            hilo_we         = (state == DIV_ISS_DONE) && !stall_ext && !flush;
        end
    end

    // Issue FSM with operand latches, result capture and the BUSY-cycle watchdog counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= DIV_ISS_IDLE;
            div.div_start  <= 1'b0;
            div.div_signed <= 1'b0;
            div.div_opr1   <= ZERO_WORD;
            div.div_opr2   <= ZERO_WORD;
            hi_out         <= ZERO_WORD;
            lo_out         <= ZERO_WORD;
            cnt            <= '0;
        end else begin
            case (state)
                DIV_ISS_IDLE: begin
                    if (ex_div_req && !flush) begin
                        div.div_opr1   <= ex_opr1;
                        div.div_opr2   <= ex_opr2;
                        div.div_signed <= ex_signed;
                        div.div_start  <= 1'b1;
                        cnt            <= '0;
                        state          <= DIV_ISS_BUSY;
                    end
                end
                DIV_ISS_BUSY: begin
                    if (flush) begin
                        div.div_start <= 1'b0;
                        state         <= DIV_ISS_IDLE;
                    end else if (div.div_ready) begin
                        hi_out        <= div.div_res[DWORD_W-1:DATA_BUS_W];
                        lo_out        <= div.div_res[DATA_BUS_W-1:0];
                        div.div_start <= 1'b0;
                        state         <= DIV_ISS_DONE;
                    end else if (cnt == CNT_LIMIT) begin
                        {hi_out, lo_out} <= ZERO_DWORD;
                        div.div_start    <= 1'b0;
                        state            <= DIV_ISS_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DIV_ISS_DONE: begin
                    if (flush || !stall_ext) begin
                        state <= DIV_ISS_IDLE;
                    end
                end
                default: begin
                    div.div_start <= 1'b0;
                    state         <= DIV_ISS_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_issuer.sv
// tb_div_issuer: drives div_issuer against a behavioural divider with programmable latency,
// checks table vectors, flush, watchdog and randomized divides against an arithmetic reference.
module tb_div_issuer;
    import div_issuer_pkg::*;

    localparam int MAX_CYC = 40;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        int          lat;
        int          stl;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        ex_div_req;
    logic        ex_signed;
    logic [31:0] ex_opr1;
    logic [31:0] ex_opr2;
    logic        flush;
    logic        stall_ext;
    logic        stall_req;
    logic        hilo_we;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        div_timeout;

    int errors = 0;
    int checks = 0;
    int we_count = 0;
    int exp_we = 0;
    int div_lat = 1;
    bit never_ready = 0;
    int lat_cnt;
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;

    vec_t vecs[9];

    div_issuer_if dif();

    div_issuer #(.MAX_CYCLES(MAX_CYC), .CNT_W(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .ex_div_req  (ex_div_req),
        .ex_signed   (ex_signed),
        .ex_opr1     (ex_opr1),
        .ex_opr2     (ex_opr2),
        .flush       (flush),
        .stall_ext   (stall_ext),
        .div         (dif),
        .stall_req   (stall_req),
        .hilo_we     (hilo_we),
        .hi_out      (hi_out),
        .lo_out      (lo_out),
        .div_timeout (div_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural divide: {remainder, quotient}; divide-by-zero gives an arbitrary but fixed answer.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Divider model: answers div_lat cycles after start, holds ready until start drops or abandon.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dif.div_ready <= 1'b0;
            dif.div_res   <= '0;
            lat_cnt       <= 0;
        end else if (!dif.div_start || dif.div_abandon) begin
            dif.div_ready <= 1'b0;
            lat_cnt       <= 0;
        end else if (!dif.div_ready && !never_ready) begin
            if (lat_cnt >= div_lat - 1) begin
                dif.div_ready <= 1'b1;
                dif.div_res   <= ref_div(dif.div_opr1, dif.div_opr2, dif.div_signed);
            end else begin
                lat_cnt <= lat_cnt + 1;
            end
        end
    end

    // Count every HI/LO write pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst && hilo_we) we_count++;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout: simulation still running, required finish");
        $fatal(1, "[TB] global timeout");
    end

    task automatic check_output(input string name, input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s.%s: got 0x%08h required 0x%08h", name, tag, got, exp);
        end
    endtask

    task automatic apply_stimulus(input string name, input logic [31:0] a, input logic [31:0] b,
                                  input logic sgn, input int lat, input int stl,
                                  input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int busy;
        bit done_seen;
        bit hold_ok;
        ex_div_req  = 1'b1;
        ex_opr1     = a;
        ex_opr2     = b;
        ex_signed   = sgn;
        flush       = 1'b0;
        stall_ext   = 1'b0;
        div_lat     = lat;
        never_ready = 1'b0;
        #1;
        check_output(name, "req_stall", 32'(stall_req), 32'd1);
        busy      = 0;
        done_seen = 1'b0;
        hold_ok   = 1'b1;
        for (int c = 0; c < 80 && !done_seen; c++) begin
            @(posedge clk); #2;
            if (stall_req) begin
                busy++;
                if (dif.div_start !== 1'b1 || dif.div_opr1 !== a || dif.div_opr2 !== b ||
                    dif.div_signed !== sgn || hilo_we !== 1'b0 || dif.div_abandon !== 1'b0 ||
                    div_timeout !== 1'b0)
                    hold_ok = 1'b0;
            end else begin
                done_seen = 1'b1;
            end
        end
        check_output(name, "busy_hold", 32'(hold_ok), 32'd1);
        check_output(name, "done_reached", 32'(done_seen), 32'd1);
        if (!done_seen) begin
            ex_div_req = 1'b0;
            return;
        end
        check_output(name, "busy_cycles", 32'(busy), 32'(lat + 1));
        check_output(name, "start_low", 32'(dif.div_start), 32'd0);
        hold_ok = 1'b1;
        for (int s = 0; s < stl; s++) begin
            stall_ext = 1'b1;
            #1;
            if (hilo_we !== 1'b0 || hi_out !== exp_hi || lo_out !== exp_lo || stall_req !== 1'b0)
                hold_ok = 1'b0;
            @(posedge clk); #2;
        end
        if (stl > 0) check_output(name, "stall_hold", 32'(hold_ok), 32'd1);
        stall_ext = 1'b0;
        #1;
        check_output(name, "hilo_we", 32'(hilo_we), 32'd1);
        check_output(name, "hi", hi_out, exp_hi);
        check_output(name, "lo", lo_out, exp_lo);
        exp_we++;
        last_hi = exp_hi;
        last_lo = exp_lo;
        @(posedge clk); #1;
        ex_div_req = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        ex_div_req = 1'b0;
        flush      = 1'b0;
        stall_ext  = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        logic [63:0] rexp;
        int          busy;
        bit          ok;
        logic        ab_lim;
        logic        to_lim;

        vecs[0] = '{"divu_100_7",    32'd100,        32'd7,          1'b0, 5,  0, 32'd2,          32'd14};
        vecs[1] = '{"div_m7_2",      32'hFFFF_FFF9,  32'd2,          1'b1, 8,  0, 32'hFFFF_FFFF,  32'hFFFF_FFFD};
        vecs[2] = '{"divu_stall3",   32'hFFFF_FFFF,  32'd16,         1'b0, 3,  3, 32'd15,         32'h0FFF_FFFF};
        vecs[3] = '{"b2b_20_3",      32'd20,         32'd3,          1'b0, 2,  0, 32'd2,          32'd6};
        vecs[4] = '{"b2b_50_8",      32'd50,         32'd8,          1'b0, 4,  0, 32'd2,          32'd6};
        vecs[5] = '{"div_7_m2",      32'd7,          32'hFFFF_FFFE,  1'b1, 1,  1, 32'd1,          32'hFFFF_FFFD};
        vecs[6] = '{"div_m8_m3",     32'hFFFF_FFF8,  32'hFFFF_FFFD,  1'b1, 12, 0, 32'hFFFF_FFFE,  32'd2};
        vecs[7] = '{"divu_5_9",      32'd5,          32'd9,          1'b0, 35, 2, 32'd5,          32'd0};
        vecs[8] = '{"ready_at_lim",  32'd1000000,    32'd1,          1'b0, 39, 0, 32'd0,          32'd1000000};

        rst        = 1'b1;
        ex_div_req = 1'b1;
        ex_signed  = 1'b1;
        ex_opr1    = 32'h1234_5678;
        ex_opr2    = 32'h9;
        flush      = 1'b1;
        stall_ext  = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check_output("reset", "div_start", 32'(dif.div_start), 32'd0);
        check_output("reset", "ctrl", 32'({stall_req, hilo_we, dif.div_abandon, div_timeout, dif.div_signed}), 32'd0);
        check_output("reset", "opr1", dif.div_opr1, 32'd0);
        check_output("reset", "opr2", dif.div_opr2, 32'd0);
        check_output("reset", "hi", hi_out, 32'd0);
        check_output("reset", "lo", lo_out, 32'd0);
        ex_div_req = 1'b0;
        flush      = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        idle_cycles(2);
        $display("[TB] reset done, running table vectors");

        for (int i = 0; i < 9; i++) begin
            apply_stimulus(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].lat,
                           vecs[i].stl, vecs[i].hi, vecs[i].lo);
            if (i != 3) idle_cycles(1);
        end

        $display("[TB] flush during BUSY");
        ex_div_req = 1'b1;
        ex_opr1    = 32'd1000;
        ex_opr2    = 32'd3;
        ex_signed  = 1'b0;
        div_lat    = 30;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        #1;
        check_output("flush", "abandon", 32'(dif.div_abandon), 32'd1);
        check_output("flush", "hilo_we", 32'(hilo_we), 32'd0);
        @(posedge clk); #1;
        flush      = 1'b0;
        ex_div_req = 1'b0;
        #1;
        check_output("flush", "idle_stall", 32'(stall_req), 32'd0);
        check_output("flush", "start_low", 32'(dif.div_start), 32'd0);
        check_output("flush", "hi_kept", hi_out, last_hi);
        check_output("flush", "lo_kept", lo_out, last_lo);
        idle_cycles(2);
        check_output("flush", "no_write", 32'(we_count), 32'(exp_we));
        apply_stimulus("after_flush_9_3", 32'd9, 32'd3, 1'b0, 3, 0, 32'd0, 32'd3);
        idle_cycles(1);

        $display("[TB] watchdog with silent divider");
        never_ready = 1'b1;
        ex_div_req  = 1'b1;
        ex_opr1     = 32'd123;
        ex_opr2     = 32'd4;
        ex_signed   = 1'b0;
        busy   = 0;
        ok     = 1'b1;
        ab_lim = 1'b0;
        to_lim = 1'b0;
        for (int k = 0; k < 80; k++) begin
            @(posedge clk); #2;
            if (!stall_req) break;
            if (busy == MAX_CYC - 1) begin
                ab_lim = dif.div_abandon;
                to_lim = div_timeout;
            end else if (dif.div_abandon !== 1'b0 || div_timeout !== 1'b0) begin
                ok = 1'b0;
            end
            busy++;
        end
        check_output("watchdog", "busy_cycles", 32'(busy), 32'(MAX_CYC));
        check_output("watchdog", "quiet_before", 32'(ok), 32'd1);
        check_output("watchdog", "abandon_at_limit", 32'(ab_lim), 32'd1);
        check_output("watchdog", "timeout_at_limit", 32'(to_lim), 32'd1);
        check_output("watchdog", "hilo_we", 32'(hilo_we), 32'd1);
        check_output("watchdog", "hi", hi_out, 32'd0);
        check_output("watchdog", "lo", lo_out, 32'd0);
        check_output("watchdog", "timeout_done", 32'(div_timeout), 32'd0);
        exp_we++;
        last_hi = 32'd0;
        last_lo = 32'd0;
        @(posedge clk); #1;
        ex_div_req  = 1'b0;
        never_ready = 1'b0;
        idle_cycles(2);

        $display("[TB] randomized divides");
        for (int n = 0; n < 20; n++) begin
            ra = $urandom;
            rb = $urandom;
            if (n % 4 == 0) rb = 32'($urandom_range(1, 20));
            if (rb == 32'd0) rb = 32'd1;
            rs = 1'($urandom_range(0, 1));
            if (rs && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd2;
            rexp = ref_div(ra, rb, rs);
            apply_stimulus($sformatf("rand%0d", n), ra, rb, rs, int'($urandom_range(1, 30)),
                           int'($urandom_range(0, 3)), rexp[63:32], rexp[31:0]);
            if ($urandom_range(0, 1) == 1) idle_cycles(1);
        end
        idle_cycles(2);
        check_output("final", "write_count", 32'(we_count), 32'(exp_we));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
